// File: rtl/ddr_pkg.sv
// Shared definitions for the DDR burst masters: word geometry, the burst
// state encoding and an address alignment helper.
package ddr_pkg;

    localparam int WordBytes = 8;
    localparam int AddrLsb   = 3;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } burst_state_e;

    // Clear the byte-offset bits so the address points at a whole 64-bit word.
    function automatic logic [31:0] align_addr(input logic [31:0] addr);
        return {addr[31:AddrLsb], {AddrLsb{1'b0}}};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO. The head word is visible on
// data_o whenever valid_o is high. A push is accepted while full only if a
// pop happens in the same cycle.
module sync_fifo #(
    parameter int Width = 64,
    parameter int Depth = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic [Width-1:0]       data_i,
    input  logic                   pop_i,
    output logic [Width-1:0]       data_o,
    output logic                   valid_o,
    output logic [$clog2(Depth):0] count_o
);

    localparam int             AddrW     = $clog2(Depth);
    localparam logic [AddrW:0] FullCount = (AddrW + 1)'(Depth);
    localparam logic [AddrW:0] OneCount  = (AddrW + 1)'(1);

    logic [Width-1:0] mem_q [Depth];
    logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AddrW:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != FullCount) || do_pop);

    // Pointer and occupancy next-state; pointers wrap naturally (Depth is a power of 2).
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AddrW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AddrW'(1);
        if (do_push && !do_pop)      count_d = count_q + OneCount;
        else if (!do_push && do_pop) count_d = count_q - OneCount;
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: sequential state always uses non-blocking assignment so every flop samples pre-edge values.
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write.
    // NOTE: the data array is deliberately not reset; the empty count already masks stale contents.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    assign valid_o = (count_q != '0);
    assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/ddr_burst_reader.sv
// Read-side burst master for the 64-bit DDR model. One (base, count) job
// becomes a stream of aligned reads, one per cycle. Each read first claims
// a FIFO slot through the credit compare, because the memory's returned
// data cannot be stalled.
module ddr_burst_reader
    import ddr_pkg::*;
#(
    parameter int ReadLatency = 16,
    parameter int FifoDepth   = 32,
    parameter int LenWidth    = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic [31:0]         base_addr_i,
    input  logic [LenWidth-1:0] word_count_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                misalign_o,
    output logic [31:0]         mem_addr_o,
    output logic                mem_read_en_o,
    output logic                mem_write_en_o,
    output logic [7:0]          mem_byte_en_o,
    input  logic [63:0]         mem_data_i,
    input  logic                mem_data_valid_i,
    output logic [63:0]         data_o,
    output logic                data_valid_o,
    input  logic                data_ready_i
);

    localparam int CntW = $clog2(FifoDepth) + 1;
    localparam int IssW = LenWidth + 1;

    // A FIFO shallower than ReadLatency+2 stays correct; the credit stall then only limits throughput.
    if (FifoDepth < ReadLatency + 2) begin : g_credit_limited
    end

    burst_state_e        state_q, state_d;
    logic [31:0]         base_q, base_d;
    logic [LenWidth-1:0] count_q, count_d;
    logic [IssW-1:0]     issued_q, issued_d;
    logic [IssW-1:0]     words_out_q, words_out_d;
    logic [CntW-1:0]     in_flight_q, in_flight_d;
    logic                misalign_q, misalign_d;

    logic [CntW-1:0]     fifo_count;
    logic                fifo_valid;
    logic                fifo_pop;
    logic                resp_accept;
    logic                credit_ok;
    logic                read_en;

    // Every read issued or in flight owns one FIFO slot.
    assign credit_ok   = ({1'b0, fifo_count} + {1'b0, in_flight_q}) < (CntW + 1)'(FifoDepth);
    assign read_en     = (state_q == ISSUE) && (issued_q < {1'b0, count_q}) && credit_ok;
    // Responses with nothing outstanding belong to a job killed by reset.
    assign resp_accept = mem_data_valid_i && (in_flight_q != '0);
    assign fifo_pop    = fifo_valid && data_ready_i;

    sync_fifo #(
        .Width (64),
        .Depth (FifoDepth)
    ) u_ret_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (resp_accept),
        .data_i  (mem_data_i),
        .pop_i   (fifo_pop),
        .data_o  (data_o),
        .valid_o (fifo_valid),
        .count_o (fifo_count)
    );

    // Outstanding-read counter: issue adds one, an accepted response removes one.
    always_comb begin
        in_flight_d = in_flight_q;
        case ({read_en, resp_accept})
            2'b10:   in_flight_d = in_flight_q + CntW'(1);
            2'b01:   in_flight_d = in_flight_q - CntW'(1);
            default: in_flight_d = in_flight_q;
        endcase
    end

    // Burst FSM next state plus job latches and progress counters.
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        count_d     = count_q;
        misalign_d  = misalign_q;
        issued_d    = issued_q + IssW'(read_en);
        words_out_d = words_out_q + IssW'(fifo_pop);
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    base_d      = align_addr(base_addr_i);
                    count_d     = word_count_i;
                    misalign_d  = |base_addr_i[AddrLsb-1:0];
                    issued_d    = '0;
                    words_out_d = '0;
                    state_d     = (word_count_i == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (read_en && (issued_d == {1'b0, count_q})) state_d = DRAIN;
            end
            DRAIN: begin
                // Look at the updated count so done_o lands right after the last accept.
                if (words_out_d == {1'b0, count_q}) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, job and counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            base_q      <= '0;
            count_q     <= '0;
            issued_q    <= '0;
            words_out_q <= '0;
            in_flight_q <= '0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            count_q     <= count_d;
            issued_q    <= issued_d;
            words_out_q <= words_out_d;
            in_flight_q <= in_flight_d;
            misalign_q  <= misalign_d;
        end
    end

    assign busy_o         = (state_q != IDLE);
    assign done_o         = (state_q == DONE);
    assign misalign_o     = misalign_q;
    assign mem_read_en_o  = read_en;
    assign mem_addr_o     = read_en ? (base_q + (32'(issued_q) << AddrLsb)) : '0;
    assign mem_write_en_o = 1'b0;
    assign mem_byte_en_o  = 8'hFF;
    assign data_valid_o   = fifo_valid;

endmodule
